// File: rtl/reg_dump_display.sv
// Register-file dump sequencer: reads each register in turn and shows its
// 16-bit value and index on five active-low seven-segment digits.
module reg_dump_display #(
    parameter int NUM_REGS     = 16,
    parameter int DWELL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        auto_mode,
    input  logic [15:0] rd_data,
    output logic [3:0]  rd_addr,
    output logic        rd_en,
    output logic [0:6]  hex0,
    output logic [0:6]  hex1,
    output logic [0:6]  hex2,
    output logic [0:6]  hex3,
    output logic [0:6]  hex_idx,
    output logic        busy,
    output logic        done
);

    // state   | meaning
    // IDLE    | waiting for start, digits blank after reset
    // READ    | rd_en high for one cycle at the current index
    // CAPTURE | rd_data valid, latched into the digits at exit
    // SHOW    | holding the digits until dwell expiry or a step edge
    // DONE    | last register shown, start restarts the scan
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_SHOW,
        S_DONE
    } state_t;

    localparam logic [3:0]  LAST_IDX   = 4'(NUM_REGS - 1);
    localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);
    localparam logic [0:6]  SEG_BLANK  = 7'b1111111;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_index;
    logic [15:0] r_dwell;
    logic        r_step_prev;
    logic [0:6]  r_hex0;
    logic [0:6]  r_hex1;
    logic [0:6]  r_hex2;
    logic [0:6]  r_hex3;
    logic [0:6]  r_hex_idx;
    logic        w_step_edge;
    logic        w_advance;
    logic        w_last;

    function automatic logic [0:6] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    // A step already high when SHOW is entered leaves r_step_prev set, so no edge.
    assign w_step_edge = step & ~r_step_prev;
    assign w_last      = (r_index == LAST_IDX);
    assign w_advance   = (r_state == S_SHOW) &&
                         (auto_mode ? (r_dwell == 16'd0) : w_step_edge);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_index     <= 4'd0;
            r_dwell     <= 16'd0;
            r_step_prev <= 1'b0;
            r_hex0      <= SEG_BLANK;
            r_hex1      <= SEG_BLANK;
            r_hex2      <= SEG_BLANK;
            r_hex3      <= SEG_BLANK;
            r_hex_idx   <= SEG_BLANK;
        end else begin
            r_state     <= w_next;
            r_step_prev <= step;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) r_index <= 4'd0;
                end
                S_CAPTURE: begin
                    r_hex0    <= seg7(rd_data[3:0]);
                    r_hex1    <= seg7(rd_data[7:4]);
                    r_hex2    <= seg7(rd_data[11:8]);
                    r_hex3    <= seg7(rd_data[15:12]);
                    r_hex_idx <= seg7(r_index);
                    r_dwell   <= DWELL_LOAD;
                end
                S_SHOW: begin
                    if (r_dwell != 16'd0) r_dwell <= r_dwell - 16'd1;
                    if (w_advance && !w_last) r_index <= r_index + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_READ;
            S_READ:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SHOW;
            S_SHOW:    if (w_advance) w_next = w_last ? S_DONE : S_READ;
            S_DONE:    if (start) w_next = S_READ;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = 4'd0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_READ: begin
                rd_en   = 1'b1;
                rd_addr = r_index;
                busy    = 1'b1;
            end
            S_CAPTURE, S_SHOW: busy = 1'b1;
            S_DONE:            done = 1'b1;
            default: ;
        endcase
    end

    assign hex0    = r_hex0;
    assign hex1    = r_hex1;
    assign hex2    = r_hex2;
    assign hex3    = r_hex3;
    assign hex_idx = r_hex_idx;

endmodule

// File: tb/tb_reg_dump_display.sv
// Scoreboard bench for reg_dump_display: random register contents, queue of
// expected reads/displays, and a negedge monitor that checks each one.
module tb_reg_dump_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        step;
    logic        auto_mode;
    logic [15:0] rd_data = 16'd0;
    logic [3:0]  rd_addr;
    logic        rd_en;
    logic [0:6]  hex0, hex1, hex2, hex3, hex_idx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    reg_dump_display #(.NUM_REGS(16), .DWELL_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .auto_mode(auto_mode),
        .rd_data(rd_data), .rd_addr(rd_addr), .rd_en(rd_en),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex_idx(hex_idx),
        .busy(busy), .done(done)
    );

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [15:0] mem [16];
    logic [6:0]  seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    localparam int BLANK = 7'h7F;
    localparam int GAP   = 4 + 2;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int cyc      = 0;
    int last_rd  = -1;
    bit p1 = 1'b0;
    bit p2 = 1'b0;

    // register file: data for the strobed address arrives one cycle later
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            p1 = 1'b0;
            p2 = 1'b0;
            last_rd = -1;
        end else begin
            if (p2) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: display update with no expected entry");
                end else begin
                    e = q.pop_front();
                    check("hex0", int'(hex0), int'(seg_tab[e.data[3:0]]));
                    check("hex1", int'(hex1), int'(seg_tab[e.data[7:4]]));
                    check("hex2", int'(hex2), int'(seg_tab[e.data[11:8]]));
                    check("hex3", int'(hex3), int'(seg_tab[e.data[15:12]]));
                    check("hex_idx", int'(hex_idx), int'(seg_tab[e.idx]));
                end
            end
            p2 = p1;
            p1 = rd_en;
            if (rd_en) begin
                rd_cnt++;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: read at addr %0d, expected none", rd_addr);
                end else begin
                    check("rd_addr", int'(rd_addr), q[0].idx);
                end
                if (auto_mode && last_rd >= 0 && rd_addr != 4'd0)
                    check("rd_gap", cyc - last_rd, GAP);
                last_rd = cyc;
            end
        end
    end

    task automatic push_range(input int lo, input int hi);
        exp_t x;
        for (int i = lo; i <= hi; i++) begin
            x.idx  = i;
            x.data = mem[i];
            q.push_back(x);
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(done), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_hex0"}, int'(hex0), BLANK);
        check({tag, "_hex3"}, int'(hex3), BLANK);
        check({tag, "_hex_idx"}, int'(hex_idx), BLANK);
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1;
        start = 1'b0;
        step = 1'b0;
        auto_mode = 1'b1;
        randomize_mem();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // first auto scan: R0 = 0, R15 = 0xF81A
        mem[0]  = 16'h0000;
        mem[15] = 16'hF81A;
        push_range(0, 15);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_rd_en", int'(rd_en), 1);
        check("start_rd_addr", int'(rd_addr), 0);
        check("start_busy", int'(busy), 1);
        wait_done(300, "auto_done");
        check("auto_busy", int'(busy), 0);
        check("auto_rd_count", rd_cnt, 16);
        check("last_hex3", int'(hex3), 7'b0111000);
        check("last_hex2", int'(hex2), 7'b0000000);
        check("last_hex1", int'(hex1), 7'b1001111);
        check("last_hex0", int'(hex0), 7'b0001000);
        check("last_hex_idx", int'(hex_idx), 7'b0111000);
        repeat (5) @(negedge clk);
        check("done_hold", int'(done), 1);
        check("done_hold_hex3", int'(hex3), 7'b0111000);
        check("sb_drained", q.size(), 0);

        // random auto scans, each restarted from DONE
        for (int s = 0; s < 2; s++) begin
            randomize_mem();
            push_range(0, 15);
            pulse_start();
            check("restart_done_low", int'(done), 0);
            wait_done(300, "rand_auto_done");
        end

        // manual mode: step held high through SHOW entry must not advance
        auto_mode = 1'b0;
        randomize_mem();
        step = 1'b1;
        base = rd_cnt;
        push_range(0, 1);
        pulse_start();
        repeat (12) @(negedge clk);
        check("step_held_reads", rd_cnt - base, 1);
        check("step_held_idx", int'(hex_idx), int'(seg_tab[0]));
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        repeat (12) @(negedge clk);
        check("step_edge_reads", rd_cnt - base, 2);
        check("step_edge_idx", int'(hex_idx), int'(seg_tab[1]));
        check("step_edge_busy", int'(busy), 1);

        // finish the manual scan with random step activity
        push_range(2, 15);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            step = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        check("manual_done", int'(done), 1);
        check("manual_reads", rd_cnt - base, 16);
        step = 1'b0;
        auto_mode = 1'b1;

        // start held high for a whole scan, then restart from DONE
        randomize_mem();
        push_range(0, 15);
        base = rd_cnt;
        start = 1'b1;
        @(negedge clk);
        wait_done(300, "held_done");
        check("held_reads", rd_cnt - base, 16);
        push_range(0, 15);
        @(negedge clk);
        check("held_restart_done", int'(done), 0);
        check("held_restart_rd_en", int'(rd_en), 1);
        check("held_restart_addr", int'(rd_addr), 0);
        start = 1'b0;
        wait_done(300, "held_second_done");

        // reset while showing index 7
        randomize_mem();
        push_range(0, 15);
        pulse_start();
        n = 0;
        while (!(busy === 1'b1 && hex_idx === seg_tab[7]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reach_idx7", int'(hex_idx), int'(seg_tab[7]));
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        q.delete();
        repeat (4) @(negedge clk);
        check("idle_after_rst", int'(busy), 0);

        // recovery scan after reset
        randomize_mem();
        push_range(0, 15);
        pulse_start();
        wait_done(300, "recover_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
